// File: rtl/bran_cmp_arbiter_pkg.sv
// Shared types and the 32-bit magnitude compare used by the branch/SLT comparator arbiter.
package bran_cmp_arbiter_pkg;

    typedef enum logic [1:0] {
        BRAN_GT = 2'd0,
        BRAN_LT = 2'd1,
        BRAN_EQ = 2'd2
    } bran_code_t;

    // Differing sign bits settle the result without looking at the magnitudes;
    // equal sign bits make the low 31 bits order correctly for both signed and unsigned.
    function automatic bran_code_t bran_cmp(input logic [31:0] rs1,
                                            input logic [31:0] rs2,
                                            input logic        sign);
        if (rs1[31] != rs2[31])
            return sign ? bran_code_t'({1'b0, rs1[31]}) : bran_code_t'({1'b0, rs2[31]});
        else if (rs1[30:0] == rs2[30:0])
            return BRAN_EQ;
        else if (rs1[30:0] > rs2[30:0])
            return BRAN_GT;
        else
            return BRAN_LT;
    endfunction

endpackage

// File: rtl/bran_cmp_arbiter_if.sv
// Request/response bundle between the issue-side requesters and the shared comparator.
interface bran_cmp_arbiter_if
    import bran_cmp_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][31:0]       req_rs1;
    logic [NREQ-1:0][31:0]       req_rs2;
    logic [NREQ-1:0]             req_sign;
    logic [NREQ-1:0][TAG_W-1:0]  req_tag;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0]             rsp_ready;
    bran_code_t                  rsp_eqz;
    logic [TAG_W-1:0]            rsp_tag;

    modport master (
        output req_valid, req_rs1, req_rs2, req_sign, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_eqz, rsp_tag
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_sign, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_eqz, rsp_tag
    );

endinterface

// File: rtl/bran_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping to 0.
module bran_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ)
                j = j - NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bran_cmp_arbiter.sv
// One shared 32-bit comparator, round-robin arbitrated, with a one-entry registered response slot.
module bran_cmp_arbiter
    import bran_cmp_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    bran_cmp_arbiter_if.slave     bus
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic             grant_any;
    logic             rsp_fire;
    logic             slot_free;
    logic             accept;
    bran_code_t       cmp_code;

    logic [NREQ-1:0]  rsp_valid_q;
    bran_code_t       rsp_eqz_q;
    logic [TAG_W-1:0] rsp_tag_q;

    bran_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .onehot (grant_oh),
        .idx    (grant_idx),
        .any    (grant_any)
    );

    // Only the owner's rsp_ready can drain the slot, since rsp_valid is one-hot.
    assign rsp_fire  = |(rsp_valid_q & bus.rsp_ready);
    assign slot_free = ~|rsp_valid_q | rsp_fire;
    assign accept    = grant_any & slot_free & ~flush;

    assign bus.req_ready = accept ? grant_oh : '0;
    assign cmp_code      = bran_cmp(bus.req_rs1[grant_idx], bus.req_rs2[grant_idx],
                                    bus.req_sign[grant_idx]);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_eqz   = rsp_eqz_q;
    assign bus.rsp_tag   = rsp_tag_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_eqz_q   <= BRAN_EQ;
            rsp_tag_q   <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            rsp_valid_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= grant_oh;
            rsp_eqz_q   <= cmp_code;
            rsp_tag_q   <= bus.req_tag[grant_idx];
            rr_ptr      <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else if (rsp_fire) begin
            rsp_valid_q <= '0;
        end
    end

    a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid_q));

    a_rsp_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (|rsp_valid_q && !rsp_fire && !flush) |=>
            ($stable(rsp_valid_q) && $stable(rsp_eqz_q) && $stable(rsp_tag_q)));

    a_no_code3 : assert property (@(posedge clk) disable iff (!rst_n)
        rsp_eqz_q != 2'b11);

endmodule

// File: tb/tb_bran_cmp_arbiter.sv
// Directed and randomised checks of the shared comparator arbiter against hand-computed results.
module tb_bran_cmp_arbiter;
    import bran_cmp_arbiter_pkg::*;

    localparam int NREQ  = 2;
    localparam int TAG_W = 4;

    logic clk;
    logic rst_n;
    logic flush;

    int n_vec;
    int n_err;

    bran_cmp_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

    bran_cmp_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        if (a == b) return 2'd2;
        if (s) return ($signed(a) < $signed(b)) ? 2'd1 : 2'd0;
        return (a < b) ? 2'd1 : 2'd0;
    endfunction

    // Drive one request on port p alone and check the response one cycle later.
    task automatic single(input string tag, input int p, input logic [31:0] a,
                          input logic [31:0] b, input logic s, input logic [3:0] t,
                          input logic [1:0] exp_code);
        bus.req_valid    = '0;
        bus.req_valid[p] = 1'b1;
        bus.req_rs1[p]   = a;
        bus.req_rs2[p]   = b;
        bus.req_sign[p]  = s;
        bus.req_tag[p]   = t;
        #1;
        check({tag, "_rdy"}, 64'(bus.req_ready), 64'(2'b01 << p));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_eqz, bus.rsp_tag},
              {2'b01 << p, exp_code, t});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  t;
        int          p;
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_sign  = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_eqz",   64'(bus.rsp_eqz),   64'd2);
        check("rst_tag",   64'(bus.rsp_tag),   64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;

        single("sgn_lt",   0, 32'hFFFF_FFFF, 32'd1,        1'b1, 4'h3, 2'd1);
        single("uns_gt",   0, 32'hFFFF_FFFF, 32'd1,        1'b0, 4'h4, 2'd0);
        single("eq_s",     0, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'h5, 2'd2);
        single("eq_u",     1, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'h6, 2'd2);
        single("gt_53",    1, 32'd5,         32'd3,        1'b0, 4'h7, 2'd0);
        single("lt_35",    1, 32'd3,         32'd5,        1'b1, 4'h8, 2'd1);
        single("max_s",    0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'h9, 2'd0);
        single("max_u",    1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 4'hA, 2'd1);
        single("neg_s",    0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 4'hB, 2'd1);

        // Round robin from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.req_rs1   = {32'd5, 32'd5};
        bus.req_rs2   = {32'd3, 32'd3};
        bus.req_sign  = 2'b00;
        bus.req_tag   = {4'hB, 4'hA};
        bus.req_valid = 2'b11;
        #1;
        check("rr_rdy0", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("rr_rsp", {bus.rsp_valid, bus.rsp_eqz, bus.rsp_tag},
                  (k % 2 == 0) ? {2'b01, 2'd0, 4'hA} : {2'b10, 2'd0, 4'hB});
        end

        // Backpressure on port 1's response; port 0's ready must be ignored.
        bus.rsp_ready = 2'b01;
        #1;
        check("bp_rdy", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {bus.rsp_valid, bus.rsp_eqz, bus.rsp_tag, bus.req_ready},
                  {2'b10, 2'd0, 4'hB, 2'b00});
        end
        bus.rsp_ready = 2'b11;
        #1;
        check("bp_release", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp_next", {bus.rsp_valid, bus.rsp_tag}, {2'b01, 4'hA});

        // Flush of a held response while both ports request.
        bus.rsp_ready = 2'b00;
        #1;
        flush = 1'b1;
        #1;
        check("fl_rdy", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("fl_valid", 64'(bus.rsp_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("fl_ptr", 64'(bus.req_ready), 64'd2);
        @(posedge clk);
        #1;
        check("fl_after", {bus.rsp_valid, bus.rsp_tag}, {2'b10, 4'hB});

        // Asynchronous reset while a response is held.
        bus.req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_drop", {bus.rsp_valid, bus.rsp_eqz, bus.rsp_tag}, {2'b00, 2'd2, 4'h0});
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_quiet", 64'(bus.rsp_valid), 64'd0);

        // Randomised back-to-back compares against the reference model.
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 10000; i++) begin
            p = int'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom;
                2:       b = a ^ 32'h8000_0000;
                default: b = a + 32'($urandom_range(0, 2)) - 32'd1;
            endcase
            s = 1'($urandom_range(0, 1));
            t = 4'($urandom_range(0, 15));
            bus.req_valid    = '0;
            bus.req_valid[p] = 1'b1;
            bus.req_rs1[p]   = a;
            bus.req_rs2[p]   = b;
            bus.req_sign[p]  = s;
            bus.req_tag[p]   = t;
            @(posedge clk);
            #1;
            check("rand", {bus.rsp_valid, bus.rsp_eqz, bus.rsp_tag},
                  {2'b01 << p, ref_cmp(a, b, s), t});
        end
        bus.req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
